// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared fetch constants (IMEM window base/width, nop encoding) and fetch-state enum
package if_fetch_stage_pkg;
  localparam logic [31:0] PC_BASE = 32'h0000_3000;
  localparam int IMEM_AW = 11;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} fetch_state_t;
endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush (bubble, keeps pc) > hold > load, rst clears all
module if_id_reg
  import if_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (flush) begin
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (!hold && load) begin
      id_instr <= instr;
      id_pc    <= pc;
      id_pc4   <= pc4;
      id_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC/FSM fetch stage driving IMEM word address, feeding IF/ID, with stall, redirect and out-of-window fault trap
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_BASE_P = PC_BASE,
  parameter int IMEM_AW_P = IMEM_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic [IMEM_AW_P-1:0] imem_addr,
  input  logic [31:0]          imem_instr,
  output logic [31:0]          id_instr,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_pc4,
  output logic                 id_valid,
  output logic                 fetch_fault,
  output logic [31:0]          fault_pc,
  output logic [31:0]          fetch_count
);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, fault_pc_d, count_d, off;
  logic bad, flush, hold, load;
  assign off = pc_q - PC_BASE_P;
  assign bad = (pc_q[1:0] != 2'b00) || (off[31:IMEM_AW_P+2] != '0);
  assign imem_addr = off[IMEM_AW_P+1:2];
  assign fetch_fault = (state_q == FAULT);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= PC_BASE_P;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fault_pc    <= fault_pc_d;
      fetch_count <= count_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc;
    count_d    = fetch_count;
    flush      = 1'b0;
    hold       = 1'b0;
    load       = 1'b0;
    if (redirect_valid) begin
      state_d = RUN;
      pc_d    = redirect_pc;
      flush   = 1'b1;
    end else if (state_q == FAULT) begin
      flush = 1'b1;
    end else if (stall) begin
      hold = 1'b1;
    end else if (bad) begin
      state_d    = FAULT;
      fault_pc_d = pc_q;
      flush      = 1'b1;
    end else begin
      pc_d    = pc_q + 32'd4;
      count_d = fetch_count + 32'd1;
      load    = 1'b1;
    end
  end
  if_id_reg u_if_id (
    .clk(clk),
    .rst(rst),
    .hold(hold),
    .flush(flush),
    .load(load),
    .instr(imem_instr),
    .pc(pc_q),
    .pc4(pc_q + 32'd4),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .id_pc4(id_pc4),
    .id_valid(id_valid)
  );
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the pipelined CPU. It holds the PC and drives the word address into the combinational instruction memory. It captures the returned instruction into the IF/ID pipeline register. It obeys stall and redirect (branch/jump flush) requests from the hazard and branch logic, and traps fetches outside the instruction-memory window.

Parameters:
PC_BASE, 32'h0000_3000, PC value at reset; byte address of IMEM word 0
IMEM_AW, 11, IMEM word-address width; window is 4*2^IMEM_AW bytes (8 KiB)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID
redirect_valid  in  1  branch/jump resolved taken; flush and load redirect_pc
redirect_pc  in  32  redirect target byte address
imem_addr  out  IMEM_AW  word address to IMEM; combinational = (pc - PC_BASE)[IMEM_AW+1:2]
imem_instr  in  32  instruction word from IMEM (combinational read, same cycle)
id_instr  out  32  IF/ID instruction; 32'h0 (nop) when bubble
id_pc  out  32  IF/ID PC of id_instr
id_pc4  out  32  id_pc + 4, for link/branch base
id_valid  out  1  IF/ID holds a real instruction
fetch_fault  out  1  level; stage is in FAULT state
fault_pc  out  32  PC that caused the fault
fetch_count  out  32  count of instructions delivered into IF/ID, wraps at 2^32

Behaviour:
- Reset (rst=1 at edge):
  - state=RUN, pc=PC_BASE.
  - id_instr=0, id_pc=0, id_pc4=0, id_valid=0.
  - fetch_fault=0, fault_pc=0, fetch_count=0.
- Internal pc register, 32 bit. Two-state FSM: RUN, FAULT.
- bad(pc) = pc[1:0]!=0 OR (pc - PC_BASE) >= 4*2^IMEM_AW, unsigned 32-bit subtract; PC below PC_BASE wraps large, so it is bad.
- Per-edge priority: rst > redirect_valid > stall > normal.
- RUN, redirect_valid=1, regardless of stall:
  - pc<=redirect_pc.
  - IF/ID becomes bubble: id_valid=0, id_instr=0, id_pc/id_pc4 hold.
  - fetch_count holds.
  - The redirect target is not fault-checked until it is fetched.
- RUN, stall=1, no redirect: pc, IF/ID, fetch_count all hold. No fault check.
- RUN, normal, bad(pc)=0:
  - id_instr<=imem_instr, id_pc<=pc, id_pc4<=pc+4, id_valid<=1.
  - pc<=pc+4, fetch_count<=fetch_count+1.
- RUN, normal, bad(pc)=1:
  - state<=FAULT, fault_pc<=pc, fetch_fault<=1.
  - IF/ID<=bubble. pc and fetch_count hold.
- FAULT, no redirect: pc holds, IF/ID bubble, stall ignored, fetch_fault=1.
- FAULT, redirect_valid=1:
  - state<=RUN, fetch_fault<=0, pc<=redirect_pc, IF/ID bubble.
  - fault_pc retains its last value.
- Latency: the instruction at pc appears on id_instr one cycle after the fetch edge. The first valid id_instr is at the second edge after reset release.
- imem_addr is purely combinational from pc. It is driven in every state; its value is don't-care when bad(pc).
- PC arithmetic is 32-bit modulo. pc+4 overflow wraps, and the wrapped value is then caught by bad().
- Simultaneous stall+redirect: redirect wins. The flushed slot is a bubble even though ID was stalled.
- Reset asserted mid-operation takes effect at the next edge from any state, overriding redirect and stall.

Decomposition:
- Shared cpu package:
  - PC_BASE constant and IMEM_AW constant, shared with the IMEM wrapper.
  - NOP_INSTR = 32'h0.
  - Fetch-state enum {RUN, FAULT}.
- One natural sub-module: if_id_reg, the IF/ID pipeline register with hold (stall) and flush (bubble) controls, reusable by later stages. PC/FSM logic stays in if_fetch_stage.

Test Plan:
1. Reset then free-run with IMEM word k = 32'h1000_0000+k → edge 2 after reset: id_pc=32'h3000, id_instr=32'h1000_0000, id_valid=1. Edge 3: id_pc=32'h3004, id_instr=32'h1000_0001. fetch_count increments by 1 per edge.
2. stall held 3 cycles when id_pc=32'h3008 → pc, id_pc, id_instr, fetch_count unchanged for 3 edges. Resumes with id_pc=32'h300C.
3. redirect_valid=1 with redirect_pc=32'h3100, plus stall=1 in the same cycle → next edge: id_valid=0, id_instr=0. Following edge: id_pc=32'h3100, id_instr=IMEM[64].
4. redirect_pc=32'h3002 (misaligned) → after the redirect edge, next edge: fetch_fault=1, fault_pc=32'h3002, id_valid=0. Stays faulted with stall toggling. redirect to 32'h3000 clears fetch_fault; id_pc=32'h3000 one edge later.
5. Sequential run off the end: redirect to 32'h4FFC → id_pc=32'h4FFC valid, then fetch_fault=1, fault_pc=32'h5000. Separately, redirect to 32'h2FFC → fault_pc=32'h2FFC.
6. rst asserted while in FAULT and also while redirect_valid=1 → next edge: all outputs at reset values, pc=32'h3000, fetch_fault=0, fetch_count=0.
